// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the parametrised two-road traffic controller:
//   - FSM state encodings (3-bit, legacy-compatible constants)
//   - lamp-pattern record and per-state lamp constants
//   - lamp_decode(): state/blink -> lamp pattern
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] ST_AR_A  = 3'd0;  // all-red guard before road 2 green
    localparam logic [2:0] ST_R1G2  = 3'd1;
    localparam logic [2:0] ST_R1Y2  = 3'd2;
    localparam logic [2:0] ST_AR_B  = 3'd3;  // all-red guard before road 1 green
    localparam logic [2:0] ST_G1R2  = 3'd4;
    localparam logic [2:0] ST_Y1R2  = 3'd5;
    localparam logic [2:0] ST_NIGHT = 3'd6;

    typedef struct packed {
        logic r1;
        logic y1;
        logic g1;
        logic r2;
        logic y2;
        logic g2;
    } lamps_t;

    localparam lamps_t LAMP_ALL_RED = lamps_t'(6'b100_100);
    localparam lamps_t LAMP_R1G2    = lamps_t'(6'b100_001);
    localparam lamps_t LAMP_R1Y2    = lamps_t'(6'b100_010);
    localparam lamps_t LAMP_G1R2    = lamps_t'(6'b001_100);
    localparam lamps_t LAMP_Y1R2    = lamps_t'(6'b010_100);

    // Unknown encodings fall back to all-red, the safe aspect.
    function automatic lamps_t lamp_decode(input logic [2:0] st, input logic blink);
        lamps_t l;
        case (st)
            ST_AR_A:  l = LAMP_ALL_RED;
            ST_R1G2:  l = LAMP_R1G2;
            ST_R1Y2:  l = LAMP_R1Y2;
            ST_AR_B:  l = LAMP_ALL_RED;
            ST_G1R2:  l = LAMP_G1R2;
            ST_Y1R2:  l = LAMP_Y1R2;
            ST_NIGHT: l = lamps_t'({1'b0, blink, 1'b0, 1'b0, blink, 1'b0});
            default:  l = LAMP_ALL_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// Free-running divider 0..CLK_DIV-1 producing a registered one-cycle pulse
// while the divider sits at CLK_DIV-1, so consumers sampling sec_tick act on
// the same edge where the divider wraps to 0.
// Ports:
//   Clk      in  system clock, rising edge
//   Rst_n    in  asynchronous active-low reset
//   clr      in  synchronous clear of divider and pulse
//   sec_tick out one-cycle pulse per CLK_DIV clocks
// -----------------------------------------------------------------------------
module sec_tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr,
    output logic sec_tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic             tick_r;

    // Next divider value with wrap at CLK_DIV-1.
    always_comb begin
        div_nxt_s = {DIV_W{1'b0}};
        if (div_r == DIV_LAST) begin
            div_nxt_s = {DIV_W{1'b0}};
        end else begin
            div_nxt_s = div_r + DIV_W'(1);
        end
    end

    // Divider and tick registers; tick is high while div_r == CLK_DIV-1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (clr) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            div_r  <= div_nxt_s;
            tick_r <= (div_nxt_s == DIV_LAST);
        end
    end

    assign sec_tick = tick_r;

endmodule

// File: rtl/traffic_ctrl_param.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_param
// Two-road traffic-light controller with parametrised phase durations, guard
// all-red phases, per-phase remaining-seconds countdown, night flashing-yellow
// mode and an optional pedestrian request.
// Optional feature macro: TRAFFIC_PED_REQ_EN (pedestrian request shortens the
// current green). Without it ped_req is accepted but ignored.
// Ports:
//   Clk, Rst_n             clock (rising) and asynchronous active-low reset
//   en                     run enable; 0 holds all-red and restarts the ring
//   night                  night flashing-yellow request (level)
//   ped_req                pedestrian request (level-sampled)
//   R1,Y1,G1 / R2,Y2,G2    lamp drives, decoded from the state register
//   remain                 seconds left in phase minus one (registered)
//   sec_tick               one-cycle pulse per second (registered)
// -----------------------------------------------------------------------------
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int CLK_DIV   = 1000,
    parameter int GREEN1_S  = 55,
    parameter int GREEN2_S  = 55,
    parameter int YELLOW_S  = 5,
    parameter int ALLRED_S  = 1,
    parameter int PED_MIN_S = 5,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             en,
    input  logic             night,
    input  logic             ped_req,
    output logic             R1,
    output logic             Y1,
    output logic             G1,
    output logic             R2,
    output logic             Y2,
    output logic             G2,
    output logic [CNT_W-1:0] remain,
    output logic             sec_tick
);

    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_S - 1);
    localparam logic [CNT_W-1:0] LD_GREEN1 = CNT_W'(GREEN1_S - 1);
    localparam logic [CNT_W-1:0] LD_GREEN2 = CNT_W'(GREEN2_S - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(PED_MIN_S - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] remain_r;
    logic [CNT_W-1:0] remain_nxt_s;
    logic             blink_r;
    logic             blink_nxt_s;
    logic             clr_s;
    logic             ped_cut_s;
    lamps_t           lamps_s;

    function automatic logic [2:0] ring_next(input logic [2:0] st);
        logic [2:0] n;
        case (st)
            ST_AR_A: n = ST_R1G2;
            ST_R1G2: n = ST_R1Y2;
            ST_R1Y2: n = ST_AR_B;
            ST_AR_B: n = ST_G1R2;
            ST_G1R2: n = ST_Y1R2;
            ST_Y1R2: n = ST_AR_A;
            default: n = ST_AR_A;
        endcase
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] phase_load(input logic [2:0] st);
        logic [CNT_W-1:0] v;
        case (st)
            ST_AR_A: v = LD_ALLRED;
            ST_R1G2: v = LD_GREEN2;
            ST_R1Y2: v = LD_YELLOW;
            ST_AR_B: v = LD_ALLRED;
            ST_G1R2: v = LD_GREEN1;
            ST_Y1R2: v = LD_YELLOW;
            default: v = LD_ALLRED;
        endcase
        return v;
    endfunction

    sec_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sec_tick_gen (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .clr      (clr_s),
        .sec_tick (sec_tick)
    );

    // Next-state logic in priority order: en, night, night exit, ped, tick.
    always_comb begin
        state_nxt_s  = state_r;
        remain_nxt_s = remain_r;
        blink_nxt_s  = blink_r;
        clr_s        = 1'b0;
        if (!en) begin
            state_nxt_s  = ST_AR_A;
            remain_nxt_s = LD_ALLRED;
            blink_nxt_s  = 1'b0;
            clr_s        = 1'b1;
        end else if (night) begin
            state_nxt_s  = ST_NIGHT;
            remain_nxt_s = CNT_ZERO;
            if (state_r != ST_NIGHT) begin
                blink_nxt_s = 1'b1;
            end else if (sec_tick) begin
                blink_nxt_s = ~blink_r;
            end else begin
                blink_nxt_s = blink_r;
            end
        end else if (state_r == ST_NIGHT) begin
            // Leaving night restarts a full second in the guard all-red.
            state_nxt_s  = ST_AR_A;
            remain_nxt_s = LD_ALLRED;
            blink_nxt_s  = 1'b0;
            clr_s        = 1'b1;
        end else if (ped_cut_s) begin
            remain_nxt_s = LD_PED;
        end else if (sec_tick) begin
            if (remain_r == CNT_ZERO) begin
                state_nxt_s  = ring_next(state_r);
                remain_nxt_s = phase_load(ring_next(state_r));
            end else begin
                remain_nxt_s = remain_r - CNT_W'(1);
            end
        end else begin
            state_nxt_s  = state_r;
            remain_nxt_s = remain_r;
        end
    end

    // Phase state, countdown and night blink registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r  <= ST_AR_A;
            remain_r <= LD_ALLRED;
            blink_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            remain_r <= remain_nxt_s;
            blink_r  <= blink_nxt_s;
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_r;
    logic ped_pend_s;
    logic ped_clr_s;

    // A request acts on the edge that samples it as well as while latched.
    assign ped_pend_s = ped_r | ped_req;
    assign ped_cut_s  = ped_pend_s &&
                        ((state_r == ST_R1G2) || (state_r == ST_G1R2)) &&
                        (remain_r > LD_PED);
    // Clear on entering a yellow (request served) or on night / disable.
    assign ped_clr_s  = !en || (state_nxt_s == ST_NIGHT) ||
                        (((state_nxt_s == ST_R1Y2) || (state_nxt_s == ST_Y1R2)) &&
                         (state_nxt_s != state_r));

    // Pedestrian request latch.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ped_r <= 1'b0;
        end else if (ped_clr_s) begin
            ped_r <= 1'b0;
        end else if (ped_req) begin
            ped_r <= 1'b1;
        end else begin
            ped_r <= ped_r;
        end
    end
`else
    logic unused_ped_s;
    assign unused_ped_s = ped_req;
    assign ped_cut_s    = 1'b0;
`endif

    assign lamps_s = lamp_decode(state_r, blink_r);
    assign R1      = lamps_s.r1;
    assign Y1      = lamps_s.y1;
    assign G1      = lamps_s.g1;
    assign R2      = lamps_s.r2;
    assign Y2      = lamps_s.y2;
    assign G2      = lamps_s.g2;
    assign remain  = remain_r;

endmodule

// File: doc/traffic_ctrl_param.md
# traffic_ctrl_param

Parametrised two-road traffic-light controller, successor to the fixed-timing two-light block. It derives a one-second tick from the system clock and sequences both roads through green, yellow and all-red phases whose durations are set by parameters. It adds a guard all-red phase between directions, a per-phase remaining-seconds output for the countdown display, a night flashing-yellow mode and an optional pedestrian request. It sits between the board button/switch inputs and the lamp/7-segment drivers.

## Interface
- CLK_DIV, 1000: system clocks per one-second tick (≥2)
- GREEN1_S, 55: road-1 green duration, seconds
- GREEN2_S, 55: road-2 green duration, seconds
- YELLOW_S, 5: yellow duration, both roads
- ALLRED_S, 1: guard all-red duration
- PED_MIN_S, 5: green seconds left after a pedestrian request
- CNT_W, 8: width of second counter/remain; all durations in 1..2^CNT_W-1
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; 0 holds all-red
- night  in  1  night mode request (level)
- ped_req  in  1  pedestrian request pulse (level-sampled, any width)
- R1, Y1, G1  out  1  road-1 lamps
- R2, Y2, G2  out  1  road-2 lamps
- remain  out  CNT_W  seconds left in current phase minus one (0 = last second)
- sec_tick  out  1  one-cycle pulse, divider at CLK_DIV-1

## Operation
- States: AR_A, R1G2, R1Y2, AR_B, G1R2, Y1R2, NIGHT. Normal ring: AR_A→R1G2→R1Y2→AR_B→G1R2→Y1R2→AR_A.
- Lamps: AR_A/AR_B R1=R2=1; R1G2 R1,G2; R1Y2 R1,Y2; G1R2 G1,R2; Y1R2 Y1,R2; NIGHT Y1=Y2=blink, others 0. Exactly one lamp per road lit outside NIGHT.
- On phase entry remain loads duration-1; each sec_tick with remain≠0 decrements; sec_tick with remain=0 moves to next phase. A phase of N seconds lasts exactly N ticks.
- Priority: Rst_n > en > night > ped_req > normal.
- en=0: synchronous; state AR_A, remain=ALLRED_S-1, divider=0, blink=0. Sequence restarts from AR_A when en returns.
- night=1 (en=1): next edge enters NIGHT, blink=1, remain=0; blink toggles on every sec_tick. night falling: next edge AR_A, remain=ALLRED_S-1, divider=0.
- Divider free-runs 0..CLK_DIV-1 while en=1, wraps to 0.

## Timing
- Reset values: AR_A, R1=R2=1, Y*/G*=0, remain=ALLRED_S-1, divider=0, sec_tick=0, ped latch=0.
- Lamps decode combinationally from state register; remain and sec_tick registered. State changes on the same edge where divider wraps.
- First tick 1 cycle... CLK_DIV cycles after reset release; period of full ring = (2·ALLRED_S+GREEN1_S+GREEN2_S+2·YELLOW_S)·CLK_DIV cycles.
- Reset mid-phase: all outputs return to reset values immediately, no wait for tick.

## Configuration
- TRAFFIC_PED_REQ_EN defined: ped_req sets a latch; while latched in R1G2 or G1R2 with remain>PED_MIN_S-1, remain loads PED_MIN_S-1 on the next edge (not tick-aligned). Latch clears on entry to R1Y2/Y1R2, en=0 or NIGHT. Request during remain≤PED_MIN_S-1 or other phases: latched, no effect until next green.
- Undefined: ped_req port present but ignored; no latch logic.

## Structure
- Package traffic_pkg: state enum, lamp-pattern constants per state.
- Sub-module sec_tick_gen (parameter CLK_DIV; Clk, Rst_n, clr, sec_tick) for the divider.

## Test plan
Use CLK_DIV=4, GREEN1_S=3, GREEN2_S=2, YELLOW_S=2, ALLRED_S=1, PED_MIN_S=1.
- Release Rst_n, en=1 -> AR_A 4 cycles, R1G2 8, R1Y2 8, AR_B 4, G1R2 12, Y1R2 8, back to AR_A at cycle 44.
- In G1R2 -> remain 2,1,0 changing on each sec_tick; sec_tick high 1 cycle every 4.
- TRAFFIC_PED_REQ_EN, ped_req pulse in G1R2 at remain=2 -> remain=0 next cycle, Y1R2 at next tick; second pulse in Y1R2 -> no change.
- night=1 during R1G2 -> next edge Y1=Y2=1, all else 0, toggling every 4 cycles; night=0 -> AR_A, R1=R2=1, remain=0.
- Rst_n low mid-G1R2 -> same cycle R1=R2=1, remain=0; en=0 with night=1 -> all-red held.
